// File: rtl/lab7soc_pio_pkg.sv
// Shared register map and edge-type encodings for the lab7soc PIO family.
package lab7soc_pio_pkg;

    localparam int unsigned PIO_ADDR_W = 2;
    localparam int unsigned PIO_DATA_W = 32;

    // Word addresses on the Avalon slave port
    typedef enum logic [PIO_ADDR_W-1:0] {
        PIO_ADDR_DATA = 2'd0,
        PIO_ADDR_RSVD = 2'd1,
        PIO_ADDR_MASK = 2'd2,
        PIO_ADDR_EDGE = 2'd3
    } pio_addr_e;

    // Which input transitions set a capture bit
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/lab7soc_pio_debounce.sv
// Two-flop synchronizer plus optional vector-wide stability filter for PIO inputs.
module lab7soc_pio_debounce #(
    parameter int unsigned     WIDTH           = 4,
    parameter int unsigned     DEBOUNCE_CYCLES = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] filtered
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Bring the asynchronous pins into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RESET_VALUE;
            sync2 <= RESET_VALUE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign filtered = sync2;
    end else begin : g_filter
        localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] filt_q;

        // sync1 != sync2 means sync2 changes on this edge, so the count restarts
        // in the same cycle the new value appears; any bit toggling restarts it.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt    <= '0;
                filt_q <= RESET_VALUE;
            end else if ((sync1 != sync2) || (sync2 == filt_q)) begin
                cnt    <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                filt_q <= sync2;
            end else begin
                cnt    <= cnt + CNT_W'(1);
            end
        end

        assign filtered = filt_q;
    end

endmodule

// File: rtl/lab7soc_key_input_pio.sv
// Avalon-MM input PIO: synchronized/debounced keys, sticky edge capture, masked level IRQ.
module lab7soc_key_input_pio
    import lab7soc_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter logic [31:0] RESET_VALUE     = 32'd0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PIO_ADDR_W-1:0] address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [PIO_DATA_W-1:0] writedata,
    output logic [PIO_DATA_W-1:0] readdata,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] filtered_d;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_mask;
    logic             wr_edge;
    logic             rd_en;

    lab7soc_pio_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (RESET_VALUE[WIDTH-1:0])
    ) u_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .filtered (filtered)
    );

    if (WIDTH < PIO_DATA_W) begin : g_unused_wd
        logic unused_writedata;
        assign unused_writedata = ^writedata[PIO_DATA_W-1:WIDTH];
    end

    // Register-access decode
    always_comb begin
        wr_mask    = chipselect && !write_n && (pio_addr_e'(address) == PIO_ADDR_MASK);
        wr_edge    = chipselect && !write_n && (pio_addr_e'(address) == PIO_ADDR_EDGE);
        rd_en      = chipselect && write_n;
        clear_bits = wr_edge ? writedata[WIDTH-1:0] : '0;
    end

    // Per-bit edge select
    always_comb begin
        edges = '0;
        case (EDGE_TYPE)
            EDGE_FALL: edges = filtered_d & ~filtered;
            EDGE_ANY:  edges = filtered_d ^ filtered;
            default:   edges = ~filtered_d & filtered;
        endcase
    end

    // Delay stage, capture (a new edge beats a simultaneous clear) and mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filtered_d   <= RESET_VALUE[WIDTH-1:0];
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            filtered_d   <= filtered;
            edge_capture <= (edge_capture & ~clear_bits) | edges;
            if (wr_mask) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    // Registered read mux; holds its value when not selected
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            case (pio_addr_e'(address))
                PIO_ADDR_DATA: readdata <= PIO_DATA_W'(filtered);
                PIO_ADDR_MASK: readdata <= PIO_DATA_W'(irq_mask);
                PIO_ADDR_EDGE: readdata <= PIO_DATA_W'(edge_capture);
                default:       readdata <= '0;
            endcase
        end
    end

    // Level interrupt from registered state only
    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_lab7soc_key_input_pio.sv
// Scoreboard bench for lab7soc_key_input_pio across several parameter sets.
module tb_lab7soc_key_input_pio;

    localparam int unsigned N_DUT = 5;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  inp   [N_DUT];
    logic [31:0] rdata [N_DUT];
    logic        irq_w [N_DUT];

    int n_vec;
    int n_err;
    logic rd_valid;

    logic [31:0] exp_val_q [$];
    int          exp_sel_q [$];
    string       exp_tag_q [$];

    // 0: rise, no debounce
    lab7soc_key_input_pio #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0), .RESET_VALUE(32'h0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[0]), .in_port(inp[0]), .irq(irq_w[0]));
    // 1: rise, debounce 8
    lab7soc_key_input_pio #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8), .RESET_VALUE(32'h0)) u_deb (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[1]), .in_port(inp[1]), .irq(irq_w[1]));
    // 2: falling edge
    lab7soc_key_input_pio #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0), .RESET_VALUE(32'h0)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[2]), .in_port(inp[2]), .irq(irq_w[2]));
    // 3: any edge
    lab7soc_key_input_pio #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0), .RESET_VALUE(32'h0)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[3]), .in_port(inp[3]), .irq(irq_w[3]));
    // 4: reset value all ones
    lab7soc_key_input_pio #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0), .RESET_VALUE(32'hF)) u_rst1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[4]), .in_port(inp[4]), .irq(irq_w[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = addr;
        writedata  = data;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Issue a read and queue the value expected one cycle later
    task automatic rd(input int sel, input logic [1:0] addr, input logic [31:0] exp, input string tag);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = addr;
        exp_val_q.push_back(exp);
        exp_sel_q.push_back(sel);
        exp_tag_q.push_back(tag);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    // Marks which edges carried a read
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_valid <= 1'b0;
        else          rd_valid <= chipselect & write_n;
    end

    // Compare read responses against the scoreboard
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_val_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                automatic int          s = exp_sel_q.pop_front();
                automatic logic [31:0] v = exp_val_q.pop_front();
                automatic string       t = exp_tag_q.pop_front();
                chk(t, rdata[s], v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        for (int i = 0; i < int'(N_DUT); i++) inp[i] = 4'h0;
        inp[4] = 4'hF;

        // Reset with all-ones input and reset value: no false edge
        tick(3);
        chk("rst_rdata", rdata[4], 32'h0);
        chk("rst_irq", 32'(irq_w[4]), 32'h0);
        reset_n = 1'b1;
        tick(3);
        rd(4, 2'd0, 32'hF, "rv_data");
        rd(4, 2'd3, 32'h0, "rv_edge");
        chk("rv_irq", 32'(irq_w[4]), 32'h0);

        // Rising edge timing, mask, W1C
        inp[0] = 4'h5;
        rd(0, 2'd0, 32'h0, "lat_d0");
        rd(0, 2'd0, 32'h0, "lat_d1");
        rd(0, 2'd3, 32'h0, "lat_e2");
        rd(0, 2'd0, 32'h5, "lat_d3");
        rd(0, 2'd3, 32'h5, "lat_e4");
        chk("irq_unmasked", 32'(irq_w[0]), 32'h0);
        wr(2'd2, 32'h1);
        chk("irq_masked", 32'(irq_w[0]), 32'h1);
        rd(0, 2'd2, 32'h1, "mask_rd");
        wr(2'd3, 32'h1);
        chk("irq_cleared", 32'(irq_w[0]), 32'h0);
        rd(0, 2'd3, 32'h4, "w1c_edge");
        wr(2'd0, 32'hF);
        rd(0, 2'd0, 32'h5, "data_ro");

        // New rise on bit0 in the same cycle as its clear: set wins
        inp[0] = 4'h4;
        tick(4);
        rd(0, 2'd3, 32'h4, "fall_ignored");
        inp[0] = 4'h5;
        tick(2);
        wr(2'd3, 32'h1);
        rd(0, 2'd3, 32'h5, "collide_edge");
        chk("collide_irq", 32'(irq_w[0]), 32'h1);

        // Falling vs any edge on bit3
        wr(2'd3, 32'hF);
        inp[2] = 4'h8;
        inp[3] = 4'h8;
        tick(3);
        rd(2, 2'd3, 32'h0, "fall_on_rise");
        rd(3, 2'd3, 32'h8, "any_on_rise");
        wr(2'd3, 32'hF);
        inp[2] = 4'h0;
        inp[3] = 4'h0;
        tick(3);
        rd(2, 2'd3, 32'h8, "fall_on_fall");
        rd(3, 2'd3, 32'h8, "any_on_fall");
        wr(2'd3, 32'hF);
        inp[2] = 4'h8;
        inp[3] = 4'h8;
        tick(3);
        rd(2, 2'd3, 32'h0, "fall_once");
        rd(3, 2'd3, 32'h8, "any_again");
        wr(2'd2, 32'hFFFF_FFF6);
        rd(3, 2'd0, 32'h8, "b2b_a0");
        rd(3, 2'd2, 32'h6, "b2b_a2");
        rd(3, 2'd3, 32'h8, "b2b_a3");
        rd(3, 2'd1, 32'h0, "b2b_a1");
        chk("any_irq_masked", 32'(irq_w[3]), 32'h0);

        // Debounce: 5-cycle glitch rejected, held level accepted after 8 cycles
        inp[1] = 4'h2;
        tick(5);
        inp[1] = 4'h0;
        tick(10);
        rd(1, 2'd0, 32'h0, "glitch_data");
        rd(1, 2'd3, 32'h0, "glitch_edge");
        inp[1] = 4'h2;
        tick(9);
        rd(1, 2'd0, 32'h0, "deb_early");
        rd(1, 2'd0, 32'h2, "deb_exact");
        rd(1, 2'd3, 32'h2, "deb_edge");
        tick(8);
        rd(1, 2'd0, 32'h2, "deb_hold");
        chk("deb_irq", 32'(irq_w[1]), 32'h1);

        // Asynchronous reset mid-debounce with capture = 0xA
        inp[3] = 4'h2;
        inp[1] = 4'h0;
        tick(3);
        rd(3, 2'd3, 32'hA, "pre_rst_edge");
        wr(2'd2, 32'hF);
        chk("pre_rst_irq", 32'(irq_w[3]), 32'h1);
        tick(2);
        chk("rd_hold", rdata[3], 32'hA);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rdata_any", rdata[3], 32'h0);
        chk("arst_irq_any", 32'(irq_w[3]), 32'h0);
        chk("arst_rdata_deb", rdata[1], 32'h0);
        chk("arst_irq_deb", 32'(irq_w[1]), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3, 2'd3, 32'h0, "post_rst_edge");
        rd(3, 2'd2, 32'h0, "post_rst_mask");
        rd(1, 2'd0, 32'h0, "post_rst_deb");

        tick(2);
        if (exp_val_q.size() != 0) chk("sb_drain", 32'(exp_val_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
